uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8 data bits, parity, 3-bit baud select) between NUM_REQ byte-producing requesters.
- Grants requesters round-robin, latches the winner's byte, drives the transmitter's data, write and enable inputs, and tracks its busy flag until the frame completes.
- Owns the transmitter's baud_select and changes it only between frames.
- Sits between requester logic and the transmitter; all signals are in the clk domain.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - transmitter-side bus between the arbiter and the shared UART transmitter
interface uart_tx_arbiter_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_en;
  logic [2:0] baud_select;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_wr,
    output tx_en,
    output baud_select,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    input  tx_en,
    input  baud_select,
    output tx_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2:0]           baud_cfg,
  uart_tx_arbiter_if.master    tx,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [2:0]         baud_q, baud_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               tx_wr_q, tx_wr_d;
  logic               tx_en_q, tx_en_d;
  logic               active_q, active_d;
  logic               timeout_err_q, timeout_err_d;

  logic [ID_W-1:0]    win_id;
  logic               win_found;

  // Round-robin pick: first set request at or above ptr, wrapping past NUM_REQ-1.
  always_comb begin : pick_winner
    int idx;
    win_id    = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Next-state and registered-output logic; pulses default low each cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    baud_d        = baud_q;
    tx_en_d       = tx_en_q;
    active_d      = active_q;
    ack_d         = '0;
    done_d        = '0;
    tx_wr_d       = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Baud only tracks the config between frames so a frame never sees a rate change.
        baud_d = baud_cfg;
        if (win_found) begin
          grant_id_d = win_id;
          tx_data_d  = req_data[8*win_id +: 8];
          ack_d      = NUM_REQ'(1) << win_id;
          tx_en_d    = 1'b1;
          tx_wr_d    = 1'b1;
          active_d   = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          // Transmitter never acknowledged the write: release the slot anyway.
          timeout_err_d = 1'b1;
          done_d        = NUM_REQ'(1) << grant_id_q;
          tx_en_d       = 1'b0;
          active_d      = 1'b0;
          state_d       = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx.tx_busy) begin
          done_d   = NUM_REQ'(1) << grant_id_q;
          tx_en_d  = 1'b0;
          active_d = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= '0;
      baud_q        <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      tx_wr_q       <= 1'b0;
      tx_en_q       <= 1'b0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      baud_q        <= baud_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      tx_wr_q       <= tx_wr_d;
      tx_en_q       <= tx_en_d;
      active_q      <= active_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx.tx_data     = tx_data_q;
  assign tx.tx_wr       = tx_wr_q;
  assign tx.tx_en       = tx_en_q;
  assign tx.baud_select = baud_q;
  assign ack            = ack_q;
  assign done           = done_q;
  assign grant_id       = grant_id_q;
  assign active         = active_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [2:0]  baud_cfg;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .NUM_REQ (4),
    .TIMEOUT (16),
    .ID_W    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .baud_cfg    (baud_cfg),
    .tx          (bus),
    .ack         (ack),
    .done        (done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  int       m_ptr    = 0;
  logic [2:0] m_baud = '0;
  int       grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
    chk({tag, "_active"}, {31'd0, active}, 32'd0);
    chk({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_txdata"}, {24'd0, bus.tx_data}, 32'd0);
    chk({tag, "_txwr"}, {31'd0, bus.tx_wr}, 32'd0);
    chk({tag, "_txen"}, {31'd0, bus.tx_en}, 32'd0);
    chk({tag, "_baud"}, {29'd0, bus.baud_select}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // One complete frame starting from IDLE at a negedge with req != 0; ends at a negedge in IDLE.
  task automatic run_frame(input int dly, input int blen, input bit stuck, input bit hold,
                           input bit mid_en, input logic [2:0] mid_baud);
    int w;
    logic [3:0] oh;
    logic [7:0] byte_exp;
    w = pick(req, m_ptr);
    oh = 4'b0001 << w;
    byte_exp = req_data[8*w +: 8];
    m_baud = baud_cfg;
    @(negedge clk);
    chk("load_ack", {28'd0, ack}, {28'd0, oh});
    chk("load_txwr", {31'd0, bus.tx_wr}, 32'd1);
    chk("load_txen", {31'd0, bus.tx_en}, 32'd1);
    chk("load_data", {24'd0, bus.tx_data}, {24'd0, byte_exp});
    chk("load_grant", {30'd0, grant_id}, w);
    chk("load_active", {31'd0, active}, 32'd1);
    chk("load_baud", {29'd0, bus.baud_select}, {29'd0, m_baud});
    if (!hold) req[w] = 1'b0;
    if (!stuck && dly == 0) bus.tx_busy = 1'b1;
    @(negedge clk);
    chk("wb_ack", {28'd0, ack}, 32'd0);
    chk("wb_txwr", {31'd0, bus.tx_wr}, 32'd0);
    chk("wb_txen", {31'd0, bus.tx_en}, 32'd1);
    if (stuck) begin
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        chk("to_early", {31'd0, timeout_err}, 32'd0);
      end
      @(negedge clk);
      chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    end else begin
      for (int i = 1; i < dly; i++) @(negedge clk);
      bus.tx_busy = 1'b1;
      for (int i = 0; i < blen; i++) begin
        @(negedge clk);
        if (i == 0 || i == blen - 1) begin
          chk("busy_txen", {31'd0, bus.tx_en}, 32'd1);
          chk("busy_done", {28'd0, done}, 32'd0);
        end
        if (mid_en && i == 0) baud_cfg = mid_baud;
      end
      bus.tx_busy = 1'b0;
      @(negedge clk);
      chk("rel_terr", {31'd0, timeout_err}, 32'd0);
    end
    chk("rel_done", {28'd0, done}, {28'd0, oh});
    chk("rel_txen", {31'd0, bus.tx_en}, 32'd0);
    chk("rel_active", {31'd0, active}, 32'd0);
    chk("rel_baud", {29'd0, bus.baud_select}, {29'd0, m_baud});
    @(negedge clk);
    chk("idle_done", {28'd0, done}, 32'd0);
    chk("idle_terr", {31'd0, timeout_err}, 32'd0);
    chk("idle_txen", {31'd0, bus.tx_en}, 32'd0);
    chk("idle_baud", {29'd0, bus.baud_select}, {29'd0, m_baud});
    m_ptr = (w + 1) % 4;
    grants.push_back(w);
  endtask

  initial begin
    int exp_c[5];
    int cnt[4];
    reset = 1'b1;
    req = '0;
    req_data = '0;
    baud_cfg = '0;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Single requester with a long frame.
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    run_frame(2, 200, 1'b0, 1'b0, 1'b0, 3'b000);

    // Reset mid-frame in WAIT_DONE, then ptr must restart at 0.
    req = 4'b1000;
    req_data = 32'h5A00_0000;
    @(negedge clk);
    chk("rm_ack", {28'd0, ack}, 32'b1000);
    req = 4'b0000;
    @(negedge clk);
    bus.tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    chk("rm_active", {31'd0, active}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus.tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rm_hold_done", {28'd0, done}, 32'd0);
    reset = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    chk("rm_nodone", {28'd0, done}, 32'd0);
    req = 4'b1010;
    req_data = 32'h3300_1100;
    run_frame(1, 5, 1'b0, 1'b0, 1'b0, 3'b000);
    chk("rm_grant1", grants[grants.size()-1], 32'd1);
    req = '0;

    // Contention: 1011 held from ptr 0.
    do_reset();
    grants.delete();
    req_data = 32'h4433_2211;
    req = 4'b1011;
    for (int f = 0; f < 5; f++) run_frame(f % 3, 3 + f, 1'b0, 1'b1, 1'b0, 3'b000);
    exp_c = '{0, 1, 3, 0, 1};
    for (int f = 0; f < 5; f++) chk("cont_order", grants[f], exp_c[f]);
    req = '0;

    // Fairness: all four held for eight frames.
    do_reset();
    grants.delete();
    req_data = 32'hD4C3_B2A1;
    req = 4'b1111;
    for (int f = 0; f < 8; f++) run_frame(1, 2, 1'b0, 1'b1, 1'b0, 3'b000);
    cnt = '{0, 0, 0, 0};
    for (int f = 0; f < 8; f++) begin
      chk("fair_order", grants[f], f % 4);
      cnt[grants[f]]++;
    end
    for (int i = 0; i < 4; i++) chk("fair_count", cnt[i], 32'd2);
    req = '0;

    // Timeout with busy stuck low, then the next request is served normally.
    req = 4'b0001;
    req_data = 32'h0000_00EE;
    run_frame(0, 0, 1'b1, 1'b0, 1'b0, 3'b000);
    req = 4'b0100;
    req_data = 32'h0077_0000;
    run_frame(3, 4, 1'b0, 1'b0, 1'b0, 3'b000);

    // Baud stability across a frame.
    baud_cfg = 3'b111;
    @(negedge clk);
    chk("baud_idle", {29'd0, bus.baud_select}, 32'b111);
    req = 4'b0010;
    run_frame(1, 10, 1'b0, 1'b0, 1'b1, 3'b000);
    @(negedge clk);
    chk("baud_new", {29'd0, bus.baud_select}, 32'b000);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      req = 4'($urandom_range(1, 15));
      req_data = $urandom;
      baud_cfg = 3'($urandom_range(0, 7));
      run_frame($urandom_range(0, 12), $urandom_range(1, 20), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), 1'b0, 3'b000);
      req = '0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
